repdet_scan: RTL and testbench

REPDET_SCAN -- requirements
Module: repdet_scan

---
 rtl/repdet_scan.sv | 136 +++++++++++++
 tb/tb_repdet_scan.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/repdet_scan.sv
// Repetition detector: scans D stored {castle_mask, board} history entries for a query.
// Optional early exit once two matches are counted is enabled by defining REPDET_EARLY_EXIT_EN.
`ifndef BOARD_WIDTH
`define BOARD_WIDTH 64
`endif

module repdet_scan #(
    parameter int REPDET_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [`BOARD_WIDTH-1:0]   repdet_board_in,
    input  logic [3:0]                repdet_castle_mask_in,
    input  logic [REPDET_WIDTH-1:0]   repdet_wr_addr_in,
    input  logic                      repdet_wr_en_in,
    input  logic [REPDET_WIDTH-1:0]   repdet_depth_in,
    input  logic                      query_valid,
    input  logic [`BOARD_WIDTH-1:0]   query_board,
    input  logic [3:0]                query_castle_mask,
    output logic                      query_ready,
    output logic                      done,
    output logic [REPDET_WIDTH-1:0]   match_count,
    output logic                      thrice_rep
);
    localparam int BW      = `BOARD_WIDTH;
    localparam int EW      = BW + 4;
    localparam int ENTRIES = 2 ** REPDET_WIDTH;
    localparam logic [REPDET_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [REPDET_WIDTH:0]   TWO     = (REPDET_WIDTH + 1)'(2);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t                  state_reg;
    logic [EW-1:0]           mem [ENTRIES];
    logic [EW-1:0]           rd_data_reg;
    logic                    rd_valid_reg;
    logic [EW-1:0]           query_reg;
    logic [REPDET_WIDTH-1:0] depth_reg;
    logic [REPDET_WIDTH-1:0] scan_addr_reg;
    logic [REPDET_WIDTH-1:0] count_reg;
    logic [REPDET_WIDTH-1:0] count_next;
    logic                    ready_reg;
    logic                    done_reg;
    logic                    thrice_reg;
    logic                    stop;
    logic                    issue;
    logic                    hit;

    // Table has no reset so history survives a search abort; read-before-write on collision.
    always_ff @(posedge clk) begin
        if (repdet_wr_en_in) begin
            mem[repdet_wr_addr_in] <= {repdet_castle_mask_in, repdet_board_in};
        end
        rd_data_reg <= mem[scan_addr_reg];
    end

`ifdef REPDET_EARLY_EXIT_EN
    assign stop = ({1'b0, count_reg} >= TWO);
`else
    assign stop = 1'b0;
`endif

    assign issue = (state_reg == SCAN) && !stop;
    assign hit   = rd_valid_reg && (rd_data_reg == query_reg);

    always_comb begin
        count_next = count_reg;
        if (hit && (count_reg != CNT_MAX)) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            ready_reg     <= 1'b1;
            done_reg      <= 1'b0;
            count_reg     <= '0;
            thrice_reg    <= 1'b0;
            rd_valid_reg  <= 1'b0;
            scan_addr_reg <= '0;
        end else begin
            rd_valid_reg <= issue;
            done_reg     <= 1'b0;
            count_reg    <= count_next;
            thrice_reg   <= ({1'b0, count_next} >= TWO);
            case (state_reg)
                IDLE: begin
                    if (query_valid) begin
                        query_reg     <= {query_castle_mask, query_board};
                        depth_reg     <= repdet_depth_in;
                        count_reg     <= '0;
                        thrice_reg    <= 1'b0;
                        scan_addr_reg <= '0;
                        ready_reg     <= 1'b0;
                        if (repdet_depth_in != '0) begin
                            state_reg <= SCAN;
                        end else begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    // On early exit the outstanding read is absorbed in this same cycle.
                    if (stop) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                    end else if (scan_addr_reg == depth_reg - 1'b1) begin
                        state_reg <= DRAIN;
                    end else begin
                        scan_addr_reg <= scan_addr_reg + 1'b1;
                    end
                end
                DRAIN: begin
                    state_reg <= DONE;
                    done_reg  <= 1'b1;
                end
                DONE: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b1;
                end
                default: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign query_ready = ready_reg;
    assign done        = done_reg;
    assign match_count = count_reg;
    assign thrice_rep  = thrice_reg;

endmodule

// File: tb/tb_repdet_scan.sv
// Bench for repdet_scan: random history plus directed scans checked against a timing-rule model.
`ifndef BOARD_WIDTH
`define BOARD_WIDTH 64
`endif

module tb_repdet_scan;
    localparam int W  = 8;
    localparam int BW = `BOARD_WIDTH;
    localparam int EW = BW + 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [EW-1:0] wr_data = '0;
    logic [W-1:0]  wr_addr = '0;
    logic          wr_en = 1'b0;
    logic [W-1:0]  depth = '0;
    logic          query_valid = 1'b0;
    logic [BW-1:0] query_board = '0;
    logic [3:0]    query_castle_mask = '0;
    logic          query_ready;
    logic          done;
    logic [W-1:0]  match_count;
    logic          thrice_rep;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    logic [EW-1:0] model_mem [256];
    logic [EW-1:0] pool [8];

    repdet_scan #(.REPDET_WIDTH(W)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .repdet_board_in       (wr_data[BW-1:0]),
        .repdet_castle_mask_in (wr_data[EW-1:BW]),
        .repdet_wr_addr_in     (wr_addr),
        .repdet_wr_en_in       (wr_en),
        .repdet_depth_in       (depth),
        .query_valid           (query_valid),
        .query_board           (query_board),
        .query_castle_mask     (query_castle_mask),
        .query_ready           (query_ready),
        .done                  (done),
        .match_count           (match_count),
        .thrice_rep            (thrice_rep)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Drive a write for the current cycle; it lands at the next rising edge.
    task automatic set_write(input int addr, input logic [EW-1:0] data);
        wr_addr = W'(addr);
        wr_data = data;
        wr_en   = 1'b1;
        model_mem[addr] = data;
    endtask

    task automatic write_cycle(input int addr, input logic [EW-1:0] data);
        @(negedge clk);
        set_write(addr, data);
    endtask

    // Entry k is read at the end of cycle n+1+k and sees every write made in earlier cycles.
    task automatic scan(input logic [EW-1:0] qe, input int d, input int wr_mode,
                        input bit pulse_mid, input string name);
        logic [EW-1:0] seen [256];
        int n, done_cyc, pulses, got_cnt, got_thr, exp_cnt, exp_cyc, second;
        @(negedge clk);
        wr_en = 1'b0;
        n = cyc;
        check({name, ":ready"}, 64'(query_ready), 64'd1);
        query_valid = 1'b1;
        query_board = qe[BW-1:0];
        query_castle_mask = qe[EW-1:BW];
        depth = W'(d);
        done_cyc = -1; pulses = 0; got_cnt = 0; got_thr = 0;
        for (int c = n + 1; c <= n + d + 6; c++) begin
            @(negedge clk);
            query_valid = 1'b0;
            wr_en = 1'b0;
            depth = W'($urandom_range(0, 255));
            query_board = BW'({$urandom, $urandom});
            if (done) begin
                pulses++;
                done_cyc = c;
                got_cnt = int'(match_count);
                got_thr = int'(thrice_rep);
            end
            if (c - n - 1 < d) seen[c - n - 1] = model_mem[c - n - 1];
            if (pulse_mid && c == n + 2) begin
                query_valid = 1'b1;
                query_board = ~qe[BW-1:0];
                depth = '0;
            end
            if (wr_mode == 1 && c == n + 2) set_write(5, qe);
            if (wr_mode == 1 && c == n + 4) set_write(3, qe);
        end
        exp_cnt = 0;
        second = -1;
        for (int k = 0; k < d; k++) begin
            if (seen[k] == qe) begin
                exp_cnt++;
                if (exp_cnt == 2 && second < 0) second = k;
            end
        end
        exp_cyc = (d == 0) ? n + 1 : n + d + 2;
`ifdef REPDET_EARLY_EXIT_EN
        if (second >= 0 && second <= d - 3) begin
            exp_cyc = n + 4 + second;
            exp_cnt = 2 + ((seen[second + 1] == qe) ? 1 : 0);
        end
`endif
        check({name, ":pulses"}, 64'(pulses), 64'd1);
        check({name, ":done_cyc"}, 64'(done_cyc - n), 64'(exp_cyc - n));
        check({name, ":count"}, 64'(got_cnt), 64'(exp_cnt));
        check({name, ":thrice"}, 64'(got_thr), (exp_cnt >= 2) ? 64'd1 : 64'd0);
        check({name, ":hold"}, 64'(match_count), 64'(exp_cnt));
        $display("txn %s depth=%0d done_at=+%0d count=%0d thrice=%0d", name, d,
                 done_cyc - n, got_cnt, got_thr);
    endtask

    initial begin
        int n, pulses, r;
        for (int i = 0; i < 4; i++) begin
            logic [BW-1:0] b;
            b = BW'({$urandom, $urandom});
            pool[i]     = {4'h3, b};
            pool[i + 4] = {4'hF, b};
        end
        // Fill the whole table; the first writes happen while reset is held.
        for (int a = 0; a < 256; a++) begin
            write_cycle(a, pool[$urandom_range(0, 7)]);
            if (a == 2) begin
                check("rst:ready", 64'(query_ready), 64'd1);
                check("rst:done", 64'(done), 64'd0);
                check("rst:count", 64'(match_count), 64'd0);
                check("rst:thrice", 64'(thrice_rep), 64'd0);
            end
            if (a == 4) reset = 1'b0;
        end

        write_cycle(0, pool[1]); write_cycle(1, pool[0]);
        write_cycle(2, pool[2]); write_cycle(3, pool[0]);
        scan(pool[0], 4, 0, 1'b0, "rep4");
        scan(pool[0], 0, 0, 1'b0, "depth0");

        write_cycle(0, pool[1]); write_cycle(1, pool[2]); write_cycle(2, pool[4]);
        scan(pool[0], 3, 0, 1'b0, "mask_diff");

        write_cycle(0, pool[0]); write_cycle(1, pool[1]); write_cycle(2, pool[2]);
        write_cycle(3, pool[3]); write_cycle(4, pool[0]); write_cycle(5, pool[5]);
        scan(pool[0], 6, 1, 1'b0, "wr_during_scan");

        scan(pool[1], 10, 0, 1'b1, "mid_pulse");

        // Abort a D=8 scan two cycles in.
        @(negedge clk);
        wr_en = 1'b0;
        query_valid = 1'b1; query_board = pool[0][BW-1:0];
        query_castle_mask = pool[0][EW-1:BW]; depth = 8'd8;
        n = cyc;
        @(negedge clk); query_valid = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        check("abort:ready", 64'(query_ready), 64'd1);
        check("abort:done", 64'(done), 64'd0);
        check("abort:count", 64'(match_count), 64'd0);
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("abort:no_done", 64'(pulses), 64'd0);
        $display("txn abort started=%0d pulses_after_reset=%0d", n, pulses);
        scan(pool[0], 8, 0, 1'b0, "after_abort");

        write_cycle(0, pool[2]); write_cycle(1, pool[2]);
        scan(pool[2], 200, 0, 1'b0, "early200");
        scan(pool[3], 255, 0, 1'b0, "full255");

        for (int t = 0; t < 10; t++) begin
            r = $urandom_range(0, 6);
            for (int w = 0; w < r; w++) write_cycle($urandom_range(0, 40), pool[$urandom_range(0, 7)]);
            scan(pool[$urandom_range(0, 7)], $urandom_range(0, 40), 0, 1'b0, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=%0d exp=0", cyc);
        $fatal(1, "timeout");
    end
endmodule
